// File: rtl/ita_activation_ctrl.sv
// Activation-unit sequencer: latches one tile config, feeds vectors into the fixed-latency
// activation datapath and buffers its results in a credit-managed output FIFO.
module ita_activation_ctrl #(
  parameter int unsigned N           = 16,
  parameter int unsigned ACT_LATENCY = 3,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned LEN_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [1:0]       cfg_activation_i,
  input  logic [LEN_W-1:0] cfg_len_i,
  input  logic             inp_valid_i,
  output logic             inp_ready_o,
  input  logic [N*8-1:0]   inp_data_i,
  output logic [N*8-1:0]   act_data_o,
  output logic [1:0]       act_activation_o,
  output logic             act_calc_en_o,
  output logic             act_calc_en_q_o,
  input  logic [N*8-1:0]   act_data_i,
  output logic             oup_valid_o,
  input  logic             oup_ready_i,
  output logic [N*8-1:0]   oup_data_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned DW    = N * 8;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned INF_W = $clog2(ACT_LATENCY + 2);

  if (ACT_LATENCY < 2) begin : g_lat_chk
    $error("ACT_LATENCY must be at least 2");
  end
  if (FIFO_DEPTH < ACT_LATENCY + 1) begin : g_depth_chk
    $error("FIFO_DEPTH must be at least ACT_LATENCY+1");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, in_cnt_q, out_cnt_q;
  logic               zero_done_q;
  logic               vld_p0_q;
  logic [ACT_LATENCY-1:0] vld_pipe_q;
  logic [INF_W-1:0]   inflight;
  logic [31:0]        used;
  logic [DW-1:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   fifo_cnt_q;
  logic               cfg_hs, accept, push, pop;

  assign cfg_hs = cfg_valid_i & cfg_ready_o;
  assign accept = inp_valid_i & inp_ready_o;
  assign push   = vld_pipe_q[ACT_LATENCY-1];
  assign pop    = oup_valid_o & oup_ready_i;

  // Beats from accept until FIFO push occupy a credit; a same-cycle pop is ignored.
  always_comb begin
    inflight = INF_W'(vld_p0_q);
    for (int i = 0; i < ACT_LATENCY; i++) begin
      inflight = inflight + INF_W'(vld_pipe_q[i]);
    end
  end

  assign used        = 32'(fifo_cnt_q) + 32'(inflight);
  assign inp_ready_o = (state_q == RUN) && (used < FIFO_DEPTH);
  assign cfg_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = ((state_q == DRAIN) && (out_cnt_q == len_q)) | zero_done_q;
  assign oup_valid_o = (fifo_cnt_q != '0);
  assign oup_data_o  = mem[rd_ptr_q];
  assign act_calc_en_o   = vld_p0_q;
  assign act_calc_en_q_o = vld_pipe_q[0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cfg_hs && (cfg_len_i != '0)) state_d = RUN;
      RUN:     if (accept && (in_cnt_q == len_q - LEN_W'(1))) state_d = DRAIN;
      DRAIN:   if (out_cnt_q == len_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= IDLE;
      len_q            <= '0;
      in_cnt_q         <= '0;
      out_cnt_q        <= '0;
      zero_done_q      <= 1'b0;
      act_activation_o <= 2'd0;
    end else begin
      state_q     <= state_d;
      zero_done_q <= cfg_hs && (cfg_len_i == '0);
      if (cfg_hs) begin
        len_q            <= cfg_len_i;
        act_activation_o <= cfg_activation_i;
        in_cnt_q         <= '0;
        out_cnt_q        <= '0;
      end else begin
        if (accept) in_cnt_q <= in_cnt_q + LEN_W'(1);
        if (pop)    out_cnt_q <= out_cnt_q + LEN_W'(1);
      end
    end
  end

  // Stage p0: accepted vector presented to the datapath; valid pipe mirrors its latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      act_data_o <= '0;
      vld_p0_q   <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      if (accept) act_data_o <= inp_data_i;
      vld_p0_q   <= accept;
      vld_pipe_q <= {vld_pipe_q[ACT_LATENCY-2:0], vld_p0_q};
    end
  end

  // Output FIFO: no bypass, so a push into an empty FIFO is visible the next cycle.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= act_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && !pop && (fifo_cnt_q == CNT_W'(FIFO_DEPTH))));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop && (fifo_cnt_q == '0)));

endmodule
